// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner
//   Conditions the raw active-low coin button and amount switches for the
//   vending machine FSM. Both are passed through 2-FF synchronizers. The button
//   is then debounced, and each debounced press becomes one coin event on a
//   valid/ready interface.
//
// Ports
//   clk_i          sole clock
//   rst_ni         synchronous active-low reset
//   coin_ni        raw coin button, active-low, asynchronous
//   amount_ni      raw amount switches, active-low, asynchronous
//   coin_ready_i   downstream accepts the pending event
//   coin_valid_o   coin event pending
//   coin_amount_o  active-high amount of the pending event, stable while valid
//   dropped_o      sticky: an accept was lost because an event was still pending
module coin_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned AMOUNT_W        = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                coin_ni,
    input  logic [AMOUNT_W-1:0] amount_ni,
    input  logic                coin_ready_i,
    output logic                coin_valid_o,
    output logic [AMOUNT_W-1:0] coin_amount_o,
    output logic                dropped_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    // The count is compared one short of the target so the flip happens on the
    // edge where the counter would otherwise reach DEBOUNCE_CYCLES.
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] StReleased    = 2'd0;
    localparam logic [1:0] StPressWait   = 2'd1;
    localparam logic [1:0] StPressed     = 2'd2;
    localparam logic [1:0] StReleaseWait = 2'd3;

    // Synchronizers; reset to 1 so they read as released / zero amount.
    logic                coin_sync1_q, coin_sync2_q;
    logic [AMOUNT_W-1:0] amt_sync1_q, amt_sync2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            coin_sync1_q <= 1'b1;
            coin_sync2_q <= 1'b1;
            amt_sync1_q  <= '1;
            amt_sync2_q  <= '1;
        end else begin
            coin_sync1_q <= coin_ni;
            coin_sync2_q <= coin_sync1_q;
            amt_sync1_q  <= amount_ni;
            amt_sync2_q  <= amt_sync1_q;
        end
    end

    logic                press_s;
    logic [AMOUNT_W-1:0] amt_s;

    assign press_s = ~coin_sync2_q;
    assign amt_s   = ~amt_sync2_q;

    // Debounce FSM. The debounced level is implied by the state:
    // StReleased/StPressWait = released, StPressed/StReleaseWait = pressed.
    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            StReleased, StPressWait: begin
                if (press_s) begin
                    if (cnt_q == CntLast) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                        accept  = 1'b1;
                    end else begin
                        state_d = StPressWait;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end
            end
            StPressed, StReleaseWait: begin
                if (!press_s) begin
                    if (cnt_q == CntLast) begin
                        state_d = StReleased;
                        cnt_d   = '0;
                    end else begin
                        state_d = StReleaseWait;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StReleased;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StReleased;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output register. A zero-amount accept is discarded entirely.
    logic                accept_nz;
    logic                valid_q;
    logic [AMOUNT_W-1:0] amount_q;
    logic                dropped_q;

    assign accept_nz = accept && (amt_s != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            amount_q  <= '0;
            dropped_q <= 1'b0;
        end else if (accept_nz && (!valid_q || coin_ready_i)) begin
            // Also covers a handshake completing on the accept edge.
            valid_q  <= 1'b1;
            amount_q <= amt_s;
        end else if (accept_nz) begin
            dropped_q <= 1'b1;
        end else if (valid_q && coin_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign coin_valid_o  = valid_q;
    assign coin_amount_o = amount_q;
    assign dropped_o     = dropped_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Testbench for coin_input_conditioner with DEBOUNCE_CYCLES = 16.
// A reference model runs on each rising edge and pushes expected events into a
// queue; a monitor on the falling edge pops and compares on every transfer and
// compares the output flags against the model every cycle.
module tb_coin_input_conditioner;

    localparam int unsigned Deb = 16;
    localparam int unsigned AW  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          coin_n;
    logic [AW-1:0] amount_n;
    logic          coin_ready;
    logic          coin_valid;
    logic [AW-1:0] coin_amount;
    logic          dropped;

    int checks   = 0;
    int failures = 0;
    int xfer_cnt = 0;
    int base;
    bit rand_ready = 1'b0;

    coin_input_conditioner #(
        .DEBOUNCE_CYCLES(Deb),
        .AMOUNT_W       (AW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .coin_ni      (coin_n),
        .amount_ni    (amount_n),
        .coin_ready_i (coin_ready),
        .coin_valid_o (coin_valid),
        .coin_amount_o(coin_amount),
        .dropped_o    (dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n edges; inputs change 3 time units after each edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
            if (rand_ready) coin_ready = 1'($urandom);
        end
    endtask

    // ---------------- reference model ----------------
    // The button and amount are seen two edges late. A level change is taken
    // once the seen button has disagreed with the debounced level for Deb
    // consecutive edges; a change to pressed is an accept.
    logic [AW-1:0] exp_q[$];
    bit            c0, c1, seen_c, lvl, press, accept;
    logic [AW-1:0] a0, a1, seen_a, m_amt_in;
    int            run;
    bit            mv, mdrop;
    logic [AW-1:0] mamt;

    task automatic model_step();
        if (!rst_n) begin
            exp_q.delete();
            c0 = 1'b1; c1 = 1'b1; a0 = '1; a1 = '1;
            lvl = 1'b0; run = 0;
            mv = 1'b0; mdrop = 1'b0; mamt = '0;
        end else begin
            seen_c = c1; c1 = c0; c0 = coin_n;
            seen_a = a1; a1 = a0; a0 = amount_n;
            press  = !seen_c;
            accept = 1'b0;
            if (press != lvl) begin
                run++;
                if (run == Deb) begin
                    lvl    = press;
                    run    = 0;
                    accept = press;
                end
            end else begin
                run = 0;
            end
            m_amt_in = ~seen_a;
            if (accept && m_amt_in != '0) begin
                if (!mv || coin_ready) begin
                    exp_q.push_back(m_amt_in);
                    mv   = 1'b1;
                    mamt = m_amt_in;
                end else begin
                    mdrop = 1'b1;
                end
            end else if (mv && coin_ready) begin
                mv = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge clk);
        check("valid", coin_valid, mv);
        check("dropped", dropped, mdrop);
        check("amount_reg", coin_amount, mamt);
        if (rst_n && coin_valid && coin_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual=%0d required=none at %0t",
                         coin_amount, $time);
            end else begin
                check("xfer_amount", coin_amount, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        coin_n     = 1'b1;
        amount_n   = 8'hFF;
        coin_ready = 1'b1;

        // 1. Reset
        step(4);
        check("rst_valid", coin_valid, 0);
        check("rst_amount", coin_amount, 0);
        check("rst_dropped", dropped, 0);
        rst_n = 1'b1;
        base  = xfer_cnt;
        step(100);
        check("idle_events", xfer_cnt - base, 0);

        // 2. Clean press, held long
        base     = xfer_cnt;
        amount_n = ~8'd50;
        coin_n   = 1'b0;
        step(17);
        check("latency_pre", coin_valid, 0);
        step(1);
        check("latency_valid", coin_valid, 1);
        check("latency_amount", coin_amount, 50);
        step(182);
        coin_n = 1'b1;
        step(40);
        check("clean_events", xfer_cnt - base, 1);

        // 3. Bounce then hold; 15-cycle glitch; 16-cycle pulse
        base = xfer_cnt;
        for (int i = 0; i < 12; i++) begin
            coin_n = ~coin_n;
            step(5);
        end
        coin_n = 1'b0;
        step(40);
        coin_n = 1'b1;
        step(40);
        check("bounce_events", xfer_cnt - base, 1);
        base   = xfer_cnt;
        coin_n = 1'b0;
        step(15);
        coin_n = 1'b1;
        step(40);
        check("glitch15_events", xfer_cnt - base, 0);
        base   = xfer_cnt;
        coin_n = 1'b0;
        step(16);
        coin_n = 1'b1;
        step(40);
        check("pulse16_events", xfer_cnt - base, 1);

        // 4. Backpressure and drop
        coin_ready = 1'b0;
        amount_n   = ~8'd50;
        coin_n     = 1'b0;
        step(30);
        coin_n = 1'b1;
        step(40);
        amount_n = ~8'd110;
        coin_n   = 1'b0;
        step(30);
        coin_n = 1'b1;
        step(40);
        check("bp_valid", coin_valid, 1);
        check("bp_amount", coin_amount, 50);
        check("bp_dropped", dropped, 1);
        coin_ready = 1'b1;
        step(1);
        coin_ready = 1'b0;
        check("bp_valid_after", coin_valid, 0);

        // 6. Reset while pending with drop set, button held through reset
        amount_n = ~8'd30;
        coin_n   = 1'b0;
        step(30);
        coin_n = 1'b1;
        step(40);
        amount_n = ~8'd70;
        coin_n   = 1'b0;
        step(30);
        check("pre_rst_dropped", dropped, 1);
        rst_n = 1'b0;
        step(1);
        check("mid_rst_valid", coin_valid, 0);
        check("mid_rst_dropped", dropped, 0);
        check("mid_rst_amount", coin_amount, 0);
        rst_n = 1'b1;
        step(17);
        check("reaccept_pre", coin_valid, 0);
        step(1);
        check("reaccept_valid", coin_valid, 1);
        check("reaccept_amount", coin_amount, 70);
        coin_ready = 1'b1;
        step(2);
        coin_n = 1'b1;
        step(40);

        // 5. Zero amount, then same-edge load
        base     = xfer_cnt;
        amount_n = 8'hFF;
        coin_n   = 1'b0;
        step(30);
        coin_n = 1'b1;
        step(40);
        check("zero_events", xfer_cnt - base, 0);
        check("zero_dropped", dropped, 0);
        coin_ready = 1'b0;
        amount_n   = ~8'd30;
        coin_n     = 1'b0;
        step(30);
        coin_n = 1'b1;
        step(40);
        amount_n = ~8'd110;
        coin_n   = 1'b0;
        step(17);
        coin_ready = 1'b1;
        step(1);
        coin_ready = 1'b0;
        check("same_edge_valid", coin_valid, 1);
        check("same_edge_amount", coin_amount, 110);
        check("same_edge_dropped", dropped, 0);
        coin_ready = 1'b1;
        step(2);
        coin_n = 1'b1;
        step(40);

        // Randomized presses with bounce and random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            amount_n = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            for (int b = $urandom_range(0, 4); b > 0; b--) begin
                coin_n = ~coin_n;
                step($urandom_range(1, 10));
            end
            coin_n = 1'b0;
            step($urandom_range(10, 40));
            if ($urandom_range(0, 1) == 1) amount_n = 8'($urandom);
            coin_n = 1'b1;
            step($urandom_range(10, 45));
        end
        rand_ready = 1'b0;
        coin_ready = 1'b1;
        step(40);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coin_input_conditioner.md
# coin_input_conditioner

Front-end stage feeding `vending_machine`. It takes the raw active-low pull-up coin button and 8-bit amount switches from the board, then synchronizes and debounces them. Each physical press becomes exactly one coin event carrying a stable active-high amount. Events are delivered through a valid/ready handshake, so the downstream FSM never sees bounce, metastability or repeated events from a held button.

## Interface
- `DEBOUNCE_CYCLES`, default 250000 (10 ms at 25 MHz): number of consecutive stable cycles required to accept a level change. Must be ≥ 1. The bench overrides it to 16.
- `AMOUNT_W`, default 8: width of the amount bus.

- `clk_i`  in  1  sole clock.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `coin_ni`  in  1  raw coin button, active-low, asynchronous to `clk_i`.
- `amount_ni`  in  AMOUNT_W  raw amount switches, active-low, asynchronous.
- `coin_ready_i`  in  1  downstream accepts the event. Tie it to 1 for a pulse-style consumer.
- `coin_valid_o`  out  1  coin event pending.
- `coin_amount_o`  out  AMOUNT_W  active-high amount of the pending event. It is stable while `coin_valid_o` is high.
- `dropped_o`  out  1  sticky flag: an event was lost because the previous one was still pending.

## Operation
- **Synchronizer.** `coin_ni` and `amount_ni` each pass through a 2-FF synchronizer. Reset value of every sync flop is 1, which means released or zero. Internal signals are the inverted synchronized values: `press_s` and `amt_s`.
- **Debouncer.** It holds the debounced level `press_d` (reset 0) and a counter of width $clog2(DEBOUNCE_CYCLES+1) (reset 0).
  - Each edge where `press_s != press_d`, the counter increments.
  - Each edge where `press_s == press_d`, the counter clears to 0. Any bounce therefore restarts the count.
  - At the edge where the counter would reach `DEBOUNCE_CYCLES`, `press_d` flips and the counter clears.
- **FSM states.**
  - RELEASED: `press_d` = 0. This is the reset state.
  - PRESS_WAIT: counting toward a press.
  - PRESSED: `press_d` = 1.
  - RELEASE_WAIT: counting toward a release.
  - Transitions: RELEASED→PRESS_WAIT when `press_s` = 1. PRESS_WAIT→RELEASED on bounce back. PRESS_WAIT→PRESSED on count done. The PRESSED↔RELEASE_WAIT transitions mirror these.
- **Accept.** The PRESS_WAIT→PRESSED transition is an accept. `amt_s` is sampled on that same edge.
  - An accept with `amt_s` = 0 is discarded: no event, no drop.
  - A held button yields exactly one accept. A new accept requires a full debounced release first.
  - Amount changes after the accept are ignored.
- **Output register.** Priority, highest first:
  1. Reset: `coin_valid_o`=0, `coin_amount_o`=0, `dropped_o`=0.
  2. Accept with nonzero amount, and either `coin_valid_o`=0 or `coin_ready_i`=1: set `coin_valid_o`=1 and load `coin_amount_o`. This covers a handshake completing on the same edge as the accept: the new event loads and nothing is dropped.
  3. Accept with nonzero amount while `coin_valid_o`=1 and `coin_ready_i`=0: `dropped_o`←1. The pending event and its amount are kept unchanged.
  4. `coin_valid_o` && `coin_ready_i`: `coin_valid_o`←0. `coin_amount_o` holds its last value.
- **Reset mid-operation.** The debounce count, FSM state, pending event and `dropped_o` are all cleared. A button still held at reset release is accepted as a new press once `DEBOUNCE_CYCLES` stable cycles complete.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- **Press latency.** Number rising edges from the first edge that samples `coin_ni` = 0 as edge 0. With no bounce, `coin_valid_o` is high after edge `DEBOUNCE_CYCLES`+1. With `DEBOUNCE_CYCLES` = 16, that is after edge 17.
- **Minimum accepted pulse.** A low pulse lasting `DEBOUNCE_CYCLES` cycles is accepted. A low pulse of `DEBOUNCE_CYCLES`−1 cycles is not.
- **Amount setup.** `amount_ni` must be stable at least 2 cycles before the accept edge.
- **Handshake.** An event transfers on any edge with `coin_valid_o` && `coin_ready_i`. `coin_valid_o` falls after that edge, unless a new accept loads on the same edge. Back-to-back events are at least 2·`DEBOUNCE_CYCLES` cycles apart.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=16 and `coin_ready_i`=1 unless stated otherwise.
1. **Reset.** Hold `rst_ni`=0 for 4 cycles with `coin_ni`=1 and `amount_ni`=8'hFF. Expect all outputs 0 during reset and no event for 100 cycles after release.
2. **Clean press.** Drive `amount_ni`=~8'd50 and `coin_ni`=0 for 200 cycles, then release. Expect exactly one `coin_valid_o` pulse, 1 cycle wide, after edge 17, with `coin_amount_o`=50. No second event while the button is held.
3. **Bounce and glitch.** Toggle `coin_ni` every 5 cycles for 60 cycles, then hold it low for 40. Expect exactly one event. A separate 15-cycle low glitch produces no event; a 16-cycle low pulse produces one.
4. **Backpressure.** Hold `coin_ready_i`=0, press with amount 50, release, then press with amount 110. Expect `coin_valid_o` held high with amount 50 and `dropped_o`=1. Raise `coin_ready_i` for 1 cycle; `coin_valid_o` is 0 on the next cycle.
5. **Zero amount and same-edge load.** A press with `amount_ni`=8'hFF produces no event and no drop. With amount 30 pending, assert `coin_ready_i` exactly on the edge where amount 110 is accepted. Expect `coin_valid_o` to stay 1, `coin_amount_o`=110, `dropped_o`=0.
6. **Reset mid-pending.** With an event pending and `dropped_o`=1, apply reset for 1 cycle. All outputs go to 0; a button still held is re-accepted 17 edges after reset release.
